// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: valid/ready bundle between CH producers and one registered
// consumer port of rr_arb_mux.
//   in_data   CH*WIDTH  channel i in bits [i*WIDTH +: WIDTH]
//   in_valid  CH        channel i presents a beat
//   in_ready  CH        channel i beat accepted this cycle
//   in_last   CH        last beat of a packet (only with RR_ARB_LOCK_EN)
//   out_data  WIDTH     registered selected data
//   out_ch    SELW      registered source channel index
//   out_valid 1         output register holds a beat
//   out_ready 1         consumer takes the output beat this cycle
// Modports: master = producer/consumer side, slave = arbiter side.
interface rr_arb_mux_if #(
  parameter int WIDTH = 5,
  parameter int CH    = 4,
  parameter int SELW  = 2
);
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
`ifdef RR_ARB_LOCK_EN
  logic [CH-1:0]       in_last;
`endif
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_ch;
  logic                out_valid;
  logic                out_ready;

`ifdef RR_ARB_LOCK_EN
  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_ch, out_valid);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_ch, out_valid);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_ch, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_ch, out_valid);
`endif
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbiter muxing CH valid/ready channels of WIDTH
// bits onto one registered output (latency 1, one beat per cycle).
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    rr_arb_mux_if.slave (channel inputs, registered output)
// Optional: define RR_ARB_LOCK_EN to add in_last and hold the grant on one
// channel until the last beat of its packet has transferred.
module rr_arb_mux #(
  parameter int WIDTH = 5,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic        clock,
  input  logic        reset,
  rr_arb_mux_if.slave bus
);

  logic [SELW-1:0]  ptr;
  logic             load;
  logic [CH-1:0]    grant;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  gnt_next;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  cidx;
  int               cand;

`ifdef RR_ARB_LOCK_EN
  logic             lock;
  logic [SELW-1:0]  lock_ch;
`endif

  // Output register can take a beat when empty or being drained this cycle.
  assign load = ~bus.out_valid | bus.out_ready;

  // First valid channel at or after ptr wins; while locked the search is
  // pinned to lock_ch so no other channel can slip in.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    cand     = 0;
    cidx     = '0;
    for (int k = 0; k < CH; k++) begin
      cand = (int'(ptr) + k) % CH;
      cidx = SELW'(cand);
`ifdef RR_ARB_LOCK_EN
      if (lock) cidx = lock_ch;
`endif
      if (!gnt_any && bus.in_valid[cidx]) begin
        gnt_any     = 1'b1;
        grant[cidx] = 1'b1;
        gnt_idx     = cidx;
        gnt_data    = WIDTH'(bus.in_data >> (cidx * WIDTH));
      end
    end
  end

  assign gnt_next     = (gnt_idx == SELW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
  assign bus.in_ready = grant & {CH{load & ~reset}};

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
`ifdef RR_ARB_LOCK_EN
      lock          <= 1'b0;
      lock_ch       <= '0;
`endif
    end else if (load) begin
      bus.out_valid <= gnt_any;
      if (gnt_any) begin
        bus.out_data <= gnt_data;
        bus.out_ch   <= gnt_idx;
`ifdef RR_ARB_LOCK_EN
        // Priority only rotates once a whole packet has gone through.
        if (bus.in_last[gnt_idx]) begin
          lock <= 1'b0;
          ptr  <= gnt_next;
        end else begin
          lock    <= 1'b1;
          lock_ch <= gnt_idx;
        end
`else
        ptr <= gnt_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;
  localparam int W  = 5;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clock;
  logic reset;

  rr_arb_mux_if #(.WIDTH(W), .CH(CH), .SELW(SW)) bus ();

  rr_arb_mux #(.WIDTH(W), .CH(CH), .SELW(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;
  bit done   = 0;
  bit mon_en = 0;

  // Scoreboard: beats expected in the output register, oldest first.
  int exp_ch[$];
  int exp_d[$];
  // Beats actually consumed at the output, for directed order checks.
  int seen_ch[$];
  int seen_d[$];

  // Reference state.
  int m_ptr     = 0;
  bit m_lock    = 0;
  int m_lock_ch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [CH*W-1:0] r;
    r = '0;
    r[0*W +: W] = W'(d0);
    r[1*W +: W] = W'(d1);
    r[2*W +: W] = W'(d2);
    r[3*W +: W] = W'(d3);
    return r;
  endfunction

  // One clock cycle: drive just after the falling edge, predict, then update
  // the reference at the rising edge.
  task automatic cycle(input bit rst, input logic [CH-1:0] v, input bit rdy,
                       input logic [CH*W-1:0] d, input logic [CH-1:0] last);
    bit found;
    int g;
    bit ld;
    logic [CH-1:0] exp_rdy;
    reset         = rst;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
`ifdef RR_ARB_LOCK_EN
    bus.in_last   = last;
`endif
    #1;
    found = 0;
    g     = 0;
    if (m_lock) begin
      if (((v >> m_lock_ch) & 1) != 0) begin
        found = 1;
        g     = m_lock_ch;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (!found && (((v >> ((m_ptr + k) % CH)) & 1) != 0)) begin
          found = 1;
          g     = (m_ptr + k) % CH;
        end
      end
    end
    ld      = (exp_ch.size() == 0) || rdy;
    exp_rdy = (found && ld && !rst) ? CH'(1 << g) : '0;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clock);
    if (rst) begin
      exp_ch.delete();
      exp_d.delete();
      m_ptr  = 0;
      m_lock = 0;
    end else if (found && ld) begin
      exp_ch.push_back(g);
      exp_d.push_back(int'((d >> (g * W)) & ((1 << W) - 1)));
`ifdef RR_ARB_LOCK_EN
      if (((last >> g) & 1) != 0) begin
        m_lock = 0;
        m_ptr  = (g + 1) % CH;
      end else begin
        m_lock    = 1;
        m_lock_ch = g;
      end
`else
      m_ptr = (g + 1) % CH;
`endif
    end
    @(negedge clock);
  endtask

  task automatic drain();
    cycle(0, '0, 1, '0, '1);
  endtask

  task automatic chk_seen(input int i, input int ch, input int d);
    if (i < seen_ch.size()) begin
      chk($sformatf("order_ch[%0d]", i), 32'(seen_ch[i]), 32'(ch));
      chk($sformatf("order_data[%0d]", i), 32'(seen_d[i]), 32'(d));
    end else begin
      chk($sformatf("order_count[%0d]", i), 32'(seen_ch.size()), 32'(i + 1));
    end
  endtask

  // Monitor: sample just before the rising edge, compare the held beat with
  // the scoreboard head and retire it when the consumer takes it.
  initial begin
    while (!done) begin
      @(negedge clock);
      #4;
      if (mon_en) begin
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ch.size() != 0));
        if (exp_ch.size() != 0 && bus.out_valid === 1'b1) begin
          chk("out_ch", 32'(bus.out_ch), 32'(exp_ch[0]));
          chk("out_data", 32'(bus.out_data), 32'(exp_d[0]));
          if (bus.out_ready === 1'b1) begin
            seen_ch.push_back(int'(bus.out_ch));
            seen_d.push_back(int'(bus.out_data));
            void'(exp_ch.pop_front());
            void'(exp_d.pop_front());
          end
        end
      end
    end
  end

  logic [CH*W-1:0] d1234;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
    bus.in_last   = '1;
`endif
    d1234 = pack(1, 2, 3, 4);
    @(negedge clock);

    // Reset with everything requesting.
    cycle(1, 4'b1111, 1, d1234, '1);
    cycle(1, 4'b1111, 1, d1234, '1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    mon_en = 1;

    // Full rate, all channels valid.
    seen_ch.delete(); seen_d.delete();
    repeat (5) cycle(0, 4'b1111, 1, d1234, '1);
    drain();
    chk_seen(0, 0, 1);
    chk_seen(1, 1, 2);
    chk_seen(2, 2, 3);
    chk_seen(3, 3, 4);
    chk_seen(4, 0, 1);

    // Sparse: ch2 alone, then ch0+ch2 from ptr=3.
    seen_ch.delete(); seen_d.delete();
    repeat (3) cycle(0, 4'b0100, 1, d1234, '1);
    repeat (2) cycle(0, 4'b0101, 1, d1234, '1);
    drain();
    chk_seen(0, 2, 3);
    chk_seen(1, 2, 3);
    chk_seen(2, 2, 3);
    chk_seen(3, 0, 1);
    chk_seen(4, 2, 3);

    // Backpressure holding ch1/9, then release.
    seen_ch.delete(); seen_d.delete();
    cycle(0, 4'b0010, 1, pack(1, 9, 3, 4), '1);
    repeat (3) cycle(0, 4'b1111, 0, pack(1, 9, 3, 4), '1);
    chk("bp_out_ch", 32'(bus.out_ch), 32'd1);
    chk("bp_out_data", 32'(bus.out_data), 32'd9);
    cycle(0, 4'b1111, 1, pack(1, 9, 3, 4), '1);
    drain();
    chk_seen(0, 1, 9);
    chk_seen(1, 2, 3);

    // Reset while a beat is held and stalled.
    seen_ch.delete(); seen_d.delete();
    cycle(0, 4'b0001, 1, d1234, '1);
    cycle(1, 4'b1111, 0, d1234, '1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    cycle(0, 4'b1111, 1, d1234, '1);
    drain();
    chk_seen(0, 0, 1);
    chk("midrst_count", 32'(seen_ch.size()), 32'd1);

`ifdef RR_ARB_LOCK_EN
    // Packet lock on ch1 with a valid gap mid-packet.
    seen_ch.delete(); seen_d.delete();
    cycle(0, 4'b0111, 1, d1234, 4'b0000);
    cycle(0, 4'b0111, 1, d1234, 4'b0000);
    cycle(0, 4'b0101, 1, d1234, 4'b0000);
    chk("lock_gap_valid", 32'(bus.out_valid), 32'd0);
    cycle(0, 4'b0111, 1, d1234, 4'b0010);
    cycle(0, 4'b0111, 1, d1234, 4'b1111);
    drain();
    chk_seen(0, 1, 2);
    chk_seen(1, 1, 2);
    chk_seen(2, 1, 2);
    chk_seen(3, 2, 3);
`endif

    // Randomized traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 59) == 0,
            CH'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0,
            (CH*W)'($urandom),
            CH'($urandom_range(0, 15)));
    end
    drain();
    drain();

    done = 1;
    @(negedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the team's fixed-width 2:1 select muxes.
- Arbitrates CH valid/ready input channels of WIDTH bits onto one registered output, using round-robin priority.
- Used where several processor-side producers share one datapath or writeback path, for example multiple result sources feeding one register-file write port.
- One output register stage: latency 1 cycle, throughput 1 beat/cycle.

Parameters:
- WIDTH, 5, data bits per channel
- CH, 4, number of input channels, 2..8
- SELW, 2, width of channel index, equal to ceil(log2(CH))

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH]
- in_valid  input  CH  channel i presents a beat
- in_ready  output  CH  channel i beat accepted this cycle (combinational)
- out_data  output  WIDTH  registered selected data
- out_ch  output  SELW  registered index of the source channel
- out_valid  output  1  out_data/out_ch hold a beat
- out_ready  input  1  consumer accepts the output beat this cycle

Behaviour:
- Reset (synchronous, reset=1 at edge) clears state:
  - out_valid=0, out_data=0, out_ch=0, ptr=0.
  - While reset=1, in_ready=0 regardless of other inputs.
  - Reset mid-transfer drops the held beat; no beat is accepted in the reset cycle.
- load = ~out_valid | out_ready: the output register may take a new beat this cycle.
- Grant (combinational):
  - Search channels ptr, ptr+1, ..., ptr+CH-1 (mod CH).
  - First channel with in_valid=1 is granted.
  - Exactly one-hot or zero.
- in_ready[i] = load & grant[i] & ~reset. A beat transfers on channel i when in_valid[i] & in_ready[i].
- On a transfer from channel g:
  - out_data <= in_data slice g.
  - out_ch <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod CH.
- If load=1 and no in_valid: out_valid <= 0; out_data/out_ch hold their old value (don't-care); ptr unchanged.
- If load=0 (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid hold.
  - All in_ready=0.
  - ptr unchanged.
- Simultaneous output drain and new accept in the same cycle is required: full rate with out_ready held at 1.
- ptr advances only on a transfer; an idle cycle never moves priority.
- in_valid may deassert without a transfer; inputs need not be held stable by this block.
- No combinational path from out_ready to out_data/out_valid. There is a path out_ready -> in_ready by design.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- With the macro:
  - Adds port in_last, input, CH bits, marking the final beat of a multi-beat packet on each channel.
  - A transfer from channel g with in_last[g]=0 sets lock=1 and lock_ch=g.
  - While lock=1, only lock_ch can be granted, even if it is not valid; other channels stall.
  - A transfer with in_last[lock_ch]=1 clears lock and sets ptr=(lock_ch+1) mod CH.
  - ptr does not advance on non-last locked beats.
  - Reset clears lock.
- Without the macro: no in_last port, no lock state, and every beat is arbitrated independently.

Test Plan:
1. Reset with all signals active:
   - Stimulus: reset=1 for 2 cycles, in_valid=4'b1111, out_ready=1.
   - Required: in_ready=4'b0000, out_valid=0, out_data=0, out_ch=0.
   - Required after reset drops: first out_ch=0.
2. Full rate, all channels valid:
   - Stimulus: ch0..ch3 data=5'd1,2,3,4; in_valid=4'b1111; out_ready=1.
   - Required: out_ch=0,1,2,3,0 and out_data=1,2,3,4,1 on consecutive cycles, each one cycle after its accept.
3. Sparse requests:
   - Stimulus: only ch2 valid for 3 cycles.
   - Required: out_ch=2 each cycle.
   - Then stimulus: ch0 and ch2 valid, with ptr=3.
   - Required: out_ch=0, then 2.
4. Backpressure:
   - Stimulus: out_valid=1 (out_ch=1, out_data=5'd9), out_ready=0 for 3 cycles, all channels valid.
   - Required: out_ch/out_data stable at 1/9 and in_ready=0000.
   - Then stimulus: out_ready=1.
   - Required: next out_ch=2 in the following cycle.
5. Reset mid-operation:
   - Stimulus: reset=1 for one cycle while out_valid=1 and out_ready=0.
   - Required: next cycle out_valid=0; first post-reset grant goes to ch0 even if ch1 was next.
6. Lock (RR_ARB_LOCK_EN):
   - Stimulus: ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch2 are continuously valid, ptr=1.
   - Required: out_ch=1,1,1, then 2.
   - Stimulus: a gap in ch1 valid mid-packet.
   - Required: out_valid drops; no other channel is granted.
